// File: rtl/vip_pkg.sv
// Shared types and constants for the multi-channel AXI4-Stream capture buffer.
package vip_pkg;

  localparam int GAP_W    = 16;
  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } vip_state_t;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module sdp_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; its contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; sees the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_mc_capture_vip.sv
// Multi-channel AXI4-Stream capture buffer with one-shot and ring modes,
// decimated capture and a registered per-channel readback port.
// Optional input-gap counter enabled by defining CAPTURE_GAP_CHECK_EN;
// without it gap_count is tied to zero and the port list is unchanged.
module axis_mc_capture_vip
  import vip_pkg::*;
#(
  parameter int TDATA_WIDTH = 16,
  parameter int NCHAN       = 2,
  parameter int SAMP        = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NCHAN*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         arm,
  input  logic                         stop,
  input  logic                         ring_mode,
  input  logic [7:0]                   skip,
  output logic                         full,
  output logic                         wrapped,
  output logic                         busy,
  output logic [$clog2(SAMP)-1:0]      wr_ptr,
  input  logic [$clog2(SAMP)-1:0]      rd_addr,
  input  logic [chan_w(NCHAN)-1:0]     rd_chan,
  output logic [TDATA_WIDTH-1:0]       rd_data,
  output logic [GAP_W-1:0]             gap_count
);

  localparam int PTR_W = $clog2(SAMP);
  localparam int CHW   = chan_w(NCHAN);

  vip_state_t        state_q;
  logic              tready_q;
  logic              ring_q;
  logic [7:0]        skip_q;
  logic [7:0]        dec_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic              full_q;
  logic              wrapped_q;
  logic [CHW-1:0]    rd_chan_q;

  logic              beat;
  logic              wr_en;
  logic              last_addr;
  logic [TDATA_WIDTH-1:0] ram_rd [NCHAN];
  logic [TDATA_WIDTH-1:0] rd_data_d;

  assign beat      = s_axis_tvalid & tready_q;
  assign wr_en     = (state_q == CAPTURE) && beat && (dec_q == 8'd0);
  assign last_addr = (wr_ptr_q == PTR_W'(SAMP - 1));

  // Capture FSM with decimation counter, write pointer and status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tready_q  <= 1'b0;
      ring_q    <= 1'b0;
      skip_q    <= '0;
      dec_q     <= '0;
      wr_ptr_q  <= '0;
      full_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      // The sink never back-pressures once out of reset.
      tready_q <= 1'b1;
      case (state_q)
        IDLE, DONE: begin
          // arm wins over a simultaneous stop, which is meaningless here.
          if (arm) begin
            state_q   <= CAPTURE;
            ring_q    <= ring_mode;
            skip_q    <= skip;
            dec_q     <= '0;
            wr_ptr_q  <= '0;
            full_q    <= 1'b0;
            wrapped_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (beat) dec_q <= (dec_q == skip_q) ? 8'd0 : dec_q + 8'd1;
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (last_addr) begin
              if (ring_q) begin
                wrapped_q <= 1'b1;
              end else begin
                state_q <= DONE;
                full_q  <= 1'b1;
              end
            end
          end
          // A kept beat in the same cycle is still written above.
          if (ring_q && stop) begin
            state_q <= DONE;
            full_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CAPTURE_GAP_CHECK_EN
  logic             seen_q;
  logic [GAP_W-1:0] gap_q;

  // Counts idle input cycles once the stream has started, saturating.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      seen_q <= 1'b0;
      gap_q  <= '0;
    end else if (state_q != CAPTURE) begin
      if (arm) begin
        seen_q <= 1'b0;
        gap_q  <= '0;
      end
    end else if (beat) begin
      seen_q <= 1'b1;
    end else if (seen_q && !s_axis_tvalid && (gap_q != '1)) begin
      gap_q <= gap_q + 1'b1;
    end
  end

  assign gap_count = gap_q;
`else
  assign gap_count = '0;
`endif

  // One RAM per channel, all sharing the write pointer and read address.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    sdp_ram #(
      .DW    (TDATA_WIDTH),
      .DEPTH (SAMP)
    ) u_ram (
      .clk     (clk),
      .rstn    (rstn),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (s_axis_tdata[c*TDATA_WIDTH +: TDATA_WIDTH]),
      .raddr_i (rd_addr),
      .rdata_o (ram_rd[c])
    );
  end

  // Channel select follows the RAM read by one cycle to stay aligned with it.
  always_ff @(posedge clk) begin
    if (!rstn) rd_chan_q <= '0;
    else       rd_chan_q <= rd_chan;
  end

  // Readback mux; out-of-range channels read as zero.
  always_comb begin
    // NOTE: default first so every path assigns rd_data_d and no latch is inferred.
    rd_data_d = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (rd_chan_q == CHW'(c)) rd_data_d = ram_rd[c];
    end
  end

  assign s_axis_tready = tready_q;
  assign full          = full_q;
  assign wrapped       = wrapped_q;
  assign busy          = (state_q == CAPTURE);
  assign wr_ptr        = wr_ptr_q;
  assign rd_data       = rd_data_d;

endmodule
